// File: rtl/core_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_io_pkg
//  Description : Shared constants and helpers for the core I/O bridge:
//                status bit positions, occupancy field offsets, serializer
//                state encoding and the bytes-per-word derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_io_pkg;

   // Status word bit positions
   localparam int STAT_OVF     = 0;
   localparam int STAT_UNF     = 1;
   localparam int STAT_TX_IDLE = 2;
   localparam int STAT_RX_NE   = 3;

   // Occupancy field offsets (each field is 8 bits wide)
   localparam int TX_OCC_LSB   = 8;
   localparam int RX_OCC_LSB   = 16;
   localparam int OCC_W        = 8;

   // TX serializer states
   typedef enum logic [0:0] {
      TX_EMPTY = 1'b0,
      TX_SEND  = 1'b1
   } tx_state_e;

   // Number of UART bytes carried by one core word
   function automatic int bytes_per_word(input int data_w, input int word_mode);
      return (word_mode != 0) ? (data_w / 8) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with occupancy
//                count. Pushes while full and pops while empty are ignored.
//                The head reads zero while the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i  && !empty_o;

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register; storage is unreset because the head is masked when empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/core_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : core_io_bridge
//  Description : Connects the pipeline I/O port to a byte-wide UART stream
//                through TX/RX FIFOs, with word-to-byte serialisation,
//                byte-to-word assembly, sticky error flags and a counter
//                of bytes accepted by the UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_io_bridge #(
   parameter int DATA_W    = 32,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16,
   parameter int WORD_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_issued,
   input  logic [DATA_W-1:0] out_data,
   output logic              out_stall,
   input  logic              in_issued,
   output logic [DATA_W-1:0] in_data,
   output logic              in_stall,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              clear_flags,
   output logic [31:0]       status,
   output logic [31:0]       result_bytes
);

   import core_io_pkg::*;

   localparam int BPW   = bytes_per_word(DATA_W, WORD_MODE);
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int TXC_W = $clog2(TX_DEPTH) + 1;
   localparam int RXC_W = $clog2(RX_DEPTH) + 1;

   // FIFO interface
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0] tx_head;
   logic [TXC_W-1:0]  tx_count;
   logic              rx_push, rx_full, rx_empty, rx_pop;
   logic [DATA_W-1:0] rx_word;
   logic [RXC_W-1:0]  rx_count;

   // Serializer state
   tx_state_e         tx_state_q, tx_state_d;
   logic [IDX_W-1:0]  tx_idx_q,   tx_idx_d;
   logic [DATA_W-1:0] tx_word_q,  tx_word_d;
   logic [DATA_W-1:0] tx_shifted;
   logic              tx_last;

   // Assembler state
   logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
   logic [DATA_W-1:0] rx_asm_q, rx_asm_d;
   logic [DATA_W-1:0] rx_lane;
   logic              rx_accept;
   logic              rx_last;

   // Flags and counter
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [31:0]       bytes_q, bytes_d;

   assign tx_push   = out_issued && !tx_full;
   assign rx_pop    = in_issued  && !rx_empty;
   assign out_stall = tx_full;
   assign in_stall  = rx_empty;

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .data_i  (out_data),
      .pop_i   (tx_pop),
      .data_o  (tx_head),
      .count_o (tx_count),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_push),
      .data_i  (rx_word),
      .pop_i   (rx_pop),
      .data_o  (in_data),
      .count_o (rx_count),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   // ---------------------------------------------------------------- TX side
   assign tx_valid   = (tx_state_q == TX_SEND);
   assign tx_last    = (tx_idx_q == IDX_W'(BPW - 1));
   assign tx_shifted = tx_word_q >> {tx_idx_q, 3'b000};
   assign tx_data    = tx_shifted[7:0];

   // Serializer next-state: load a word when idle, chain the next word on the last byte
   always_comb begin
      tx_state_d = tx_state_q;
      tx_idx_d   = tx_idx_q;
      tx_word_d  = tx_word_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_EMPTY: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_word_d  = tx_head;
               tx_idx_d   = '0;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (tx_ready) begin
               if (tx_last) begin
                  tx_idx_d = '0;
                  if (!tx_empty) begin
                     tx_pop    = 1'b1;
                     tx_word_d = tx_head;
                  end else begin
                     tx_state_d = TX_EMPTY;
                  end
               end else begin
                  tx_idx_d = tx_idx_q + 1'b1;
               end
            end
         end
         default: tx_state_d = TX_EMPTY;
      endcase
   end

   // Serializer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_EMPTY;
         tx_idx_q   <= '0;
         tx_word_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_idx_q   <= tx_idx_d;
         tx_word_q  <= tx_word_d;
      end
   end

   // ---------------------------------------------------------------- RX side
   assign rx_ready  = !rx_full;
   assign rx_accept = rx_valid && rx_ready;
   assign rx_last   = (rx_idx_q == IDX_W'(BPW - 1));
   assign rx_lane   = DATA_W'(rx_data) << {rx_idx_q, 3'b000};
   assign rx_word   = rx_asm_q | rx_lane;

   // Assembler next-state: merge each byte into its lane, push on the last lane
   always_comb begin
      rx_asm_d = rx_asm_q;
      rx_idx_d = rx_idx_q;
      rx_push  = 1'b0;
      if (rx_accept) begin
         if (rx_last) begin
            rx_push  = 1'b1;
            rx_asm_d = '0;
            rx_idx_d = '0;
         end else begin
            rx_asm_d = rx_word;
            rx_idx_d = rx_idx_q + 1'b1;
         end
      end
   end

   // Assembler registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_asm_q <= '0;
         rx_idx_q <= '0;
      end else begin
         rx_asm_q <= rx_asm_d;
         rx_idx_q <= rx_idx_d;
      end
   end

   // ------------------------------------------------------- flags and count
   // A new error in the same cycle as a clear wins, so the flag stays set
   always_comb begin
      ovf_d   = (ovf_q && !clear_flags) || (out_issued && tx_full);
      unf_d   = (unf_q && !clear_flags) || (in_issued  && rx_empty);
      bytes_d = bytes_q + ((tx_valid && tx_ready) ? 32'd1 : 32'd0);
   end

   // Sticky flags and sent-byte counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         bytes_q <= '0;
      end else begin
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         bytes_q <= bytes_d;
      end
   end

   assign result_bytes = bytes_q;

   // Status word assembly
   always_comb begin
      status                          = '0;
      status[STAT_OVF]                = ovf_q;
      status[STAT_UNF]                = unf_q;
      status[STAT_TX_IDLE]            = tx_empty && (tx_state_q == TX_EMPTY);
      status[STAT_RX_NE]              = !rx_empty;
      status[TX_OCC_LSB +: OCC_W]     = OCC_W'(tx_count);
      status[RX_OCC_LSB +: OCC_W]     = OCC_W'(rx_count);
   end

endmodule
`default_nettype wire

// File: tb/tb_core_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_io_bridge
//  Description : Self-checking bench for core_io_bridge (DATA_W=32,
//                TX_DEPTH=4, RX_DEPTH=2, WORD_MODE=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_io_bridge;

   logic        clk;
   logic        rst;
   logic        out_issued;
   logic [31:0] out_data;
   logic        out_stall;
   logic        in_issued;
   logic [31:0] in_data;
   logic        in_stall;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        clear_flags;
   logic [31:0] status;
   logic [31:0] result_bytes;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic [7:0]  exp_tx_q [$];
   logic [31:0] exp_rx_q [$];

   core_io_bridge #(
      .DATA_W    (32),
      .TX_DEPTH  (4),
      .RX_DEPTH  (2),
      .WORD_MODE (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .out_issued   (out_issued),
      .out_data     (out_data),
      .out_stall    (out_stall),
      .in_issued    (in_issued),
      .in_data      (in_data),
      .in_stall     (in_stall),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .clear_flags  (clear_flags),
      .status       (status),
      .result_bytes (result_bytes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset with all inputs idle; returns at posedge+1 with rst released
   task automatic do_reset();
      out_issued  = 1'b0;
      out_data    = '0;
      in_issued   = 1'b0;
      tx_ready    = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = '0;
      clear_flags = 1'b0;
      rst         = 1'b0;
      exp_tx_q.delete();
      exp_rx_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Drive one word for one cycle; queue its bytes LSB first if it should be accepted
   task automatic push_word(input logic [31:0] w, input bit accepted);
      out_issued = 1'b1;
      out_data   = w;
      if (accepted)
         for (int b = 0; b < 4; b++) exp_tx_q.push_back(w[8*b +: 8]);
      @(posedge clk);
      #1 out_issued = 1'b0;
   endtask

   // Pop and compare each UART beat against the scoreboard
   task automatic drain_tx(input int budget, output int nbytes, output int bubbles);
      int first;
      int last;
      logic [7:0] e;
      nbytes = 0;
      first  = -1;
      last   = -1;
      for (int cyc = 0; cyc < budget && exp_tx_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            e = exp_tx_q.pop_front();
            tot_cnt++;
            if (tx_data !== e) $display("FAIL tx_byte: got %h expected %h", tx_data, e);
            else pass_cnt++;
            nbytes++;
            if (first < 0) first = cyc;
            last = cyc;
         end
      end
      tot_cnt++;
      if (exp_tx_q.size() != 0) begin
         $display("FAIL tx_drain_timeout: %0d bytes outstanding expected 0", exp_tx_q.size());
         exp_tx_q.delete();
      end else pass_cnt++;
      bubbles = (nbytes > 0) ? (last - first + 1 - nbytes) : 0;
      @(posedge clk);
      #1;
   endtask

   // Offer one byte on the UART RX side until accepted (bounded)
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
      end
      if (!ok) begin
         tot_cnt++;
         $display("FAIL rx_accept_timeout: byte %h not accepted, rx_ready=%b expected 1", b, rx_ready);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Pop one word from the core side, comparing the head against the scoreboard
   task automatic pop_word(input string name);
      logic [31:0] e;
      @(negedge clk);
      e = exp_rx_q.pop_front();
      tot_cnt++;
      if (in_stall !== 1'b0 || in_data !== e)
         $display("FAIL %s: in_stall=%b in_data=%h expected in_stall=0 in_data=%h", name, in_stall, in_data, e);
      else pass_cnt++;
      @(posedge clk);
      #1 in_issued = 1'b1;
      @(posedge clk);
      #1 in_issued = 1'b0;
   endtask

   task automatic test_reset();
      out_issued = 1'b0; out_data = '0; in_issued = 1'b0; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_data = '0; clear_flags = 1'b0; rst = 1'b0;
      #3;
      tot_cnt++; if (out_stall !== 1'b0) $display("FAIL rst_out_stall: got %b expected 0", out_stall); else pass_cnt++;
      tot_cnt++; if (in_stall !== 1'b1) $display("FAIL rst_in_stall: got %b expected 1", in_stall); else pass_cnt++;
      tot_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); else pass_cnt++;
      tot_cnt++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b expected 1", rx_ready); else pass_cnt++;
      tot_cnt++; if (in_data !== 32'h0) $display("FAIL rst_in_data: got %h expected 0", in_data); else pass_cnt++;
      tot_cnt++; if (status !== 32'h4) $display("FAIL rst_status: got %h expected 00000004", status); else pass_cnt++;
      tot_cnt++; if (result_bytes !== 32'h0) $display("FAIL rst_result: got %h expected 0", result_bytes); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_single_word();
      int n, bub;
      do_reset();
      tx_ready = 1'b1;
      push_word(32'h44332211, 1'b1);
      drain_tx(30, n, bub);
      tot_cnt++; if (n != 4 || bub != 0) $display("FAIL single_beats: got %0d bytes %0d bubbles expected 4 and 0", n, bub); else pass_cnt++;
      tot_cnt++; if (result_bytes !== 32'd4) $display("FAIL single_result: got %0d expected 4", result_bytes); else pass_cnt++;
      tot_cnt++; if (status[2] !== 1'b1) $display("FAIL single_tx_idle: got %b expected 1", status[2]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n, bub;
      do_reset();
      tx_ready = 1'b1;
      push_word(32'hAABBCCDD, 1'b1);
      push_word(32'h01020304, 1'b1);
      drain_tx(40, n, bub);
      tot_cnt++; if (n != 8 || bub != 0) $display("FAIL b2b_beats: got %0d bytes %0d bubbles expected 8 and 0", n, bub); else pass_cnt++;
      tot_cnt++; if (result_bytes !== 32'd8) $display("FAIL b2b_result: got %0d expected 8", result_bytes); else pass_cnt++;
   endtask

   task automatic test_tx_full();
      int n, bub;
      do_reset();
      tx_ready = 1'b0;
      // One word moves into the serializer, so five pushes fill four entries
      for (int i = 0; i < 5; i++) push_word(32'h10000000 + i, 1'b1);
      @(negedge clk);
      tot_cnt++; if (out_stall !== 1'b1) $display("FAIL full_out_stall: got %b expected 1", out_stall); else pass_cnt++;
      tot_cnt++; if (status[15:8] !== 8'd4) $display("FAIL full_tx_occ: got %0d expected 4", status[15:8]); else pass_cnt++;
      tot_cnt++; if (status[0] !== 1'b0) $display("FAIL full_no_ovf_yet: got %b expected 0", status[0]); else pass_cnt++;
      @(posedge clk); #1;
      push_word(32'hDEAD0000, 1'b0);
      @(negedge clk);
      tot_cnt++; if (status[0] !== 1'b1) $display("FAIL ovf_set: got %b expected 1", status[0]); else pass_cnt++;
      tot_cnt++; if (status[15:8] !== 8'd4) $display("FAIL ovf_occ: got %0d expected 4", status[15:8]); else pass_cnt++;
      @(posedge clk); #1 clear_flags = 1'b1;
      @(posedge clk); #1 clear_flags = 1'b0;
      @(negedge clk);
      tot_cnt++; if (status[0] !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", status[0]); else pass_cnt++;
      @(posedge clk); #1;
      clear_flags = 1'b1;
      push_word(32'hDEAD0001, 1'b0);
      clear_flags = 1'b0;
      @(negedge clk);
      tot_cnt++; if (status[0] !== 1'b1) $display("FAIL ovf_clear_collision: got %b expected 1", status[0]); else pass_cnt++;
      @(posedge clk); #1 clear_flags = 1'b1;
      @(posedge clk); #1 clear_flags = 1'b0;
      tx_ready = 1'b1;
      drain_tx(100, n, bub);
      tot_cnt++; if (n != 20 || result_bytes !== 32'd20) $display("FAIL full_drain: got %0d bytes result %0d expected 20", n, result_bytes); else pass_cnt++;
   endtask

   task automatic test_rx_word();
      do_reset();
      send_byte(8'hEF);
      send_byte(8'hBE);
      send_byte(8'hAD);
      @(negedge clk);
      tot_cnt++; if (in_stall !== 1'b1) $display("FAIL rx_partial_stall: got %b expected 1", in_stall); else pass_cnt++;
      @(posedge clk); #1;
      send_byte(8'hDE);
      @(negedge clk);
      tot_cnt++; if (in_stall !== 1'b0) $display("FAIL rx_word_stall: got %b expected 0", in_stall); else pass_cnt++;
      tot_cnt++; if (in_data !== 32'hDEADBEEF) $display("FAIL rx_word_data: got %h expected deadbeef", in_data); else pass_cnt++;
      tot_cnt++; if (status[3] !== 1'b1 || status[23:16] !== 8'd1) $display("FAIL rx_status: got %h expected bit3=1 rxocc=1", status); else pass_cnt++;
      @(posedge clk); #1 in_issued = 1'b1;
      @(posedge clk); #1 in_issued = 1'b0;
      @(negedge clk);
      tot_cnt++; if (in_stall !== 1'b1 || status[1] !== 1'b0) $display("FAIL rx_pop: in_stall=%b unf=%b expected 1 and 0", in_stall, status[1]); else pass_cnt++;
      @(posedge clk); #1 in_issued = 1'b1;
      @(posedge clk); #1 in_issued = 1'b0;
      @(negedge clk);
      tot_cnt++; if (status[1] !== 1'b1) $display("FAIL rx_underflow: got %b expected 1", status[1]); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_rx_backpressure();
      logic [7:0]  b [12];
      logic [31:0] w;
      do_reset();
      for (int i = 0; i < 12; i++) b[i] = 8'h10 + 8'(i);
      for (int k = 0; k < 3; k++) begin
         w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
         exp_rx_q.push_back(w);
      end
      for (int i = 0; i < 8; i++) send_byte(b[i]);
      @(negedge clk);
      tot_cnt++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready: got %b expected 0", rx_ready); else pass_cnt++;
      @(posedge clk); #1;
      // Byte 8 waits while the RX FIFO is full
      rx_valid = 1'b1;
      rx_data  = b[8];
      repeat (3) @(posedge clk);
      @(negedge clk);
      tot_cnt++; if (rx_ready !== 1'b0 || status[23:16] !== 8'd2) $display("FAIL rx_hold: rx_ready=%b rxocc=%0d expected 0 and 2", rx_ready, status[23:16]); else pass_cnt++;
      @(posedge clk); #1;
      pop_word("rx_bp_word0");
      for (int i = 8; i < 12; i++) send_byte(b[i]);
      pop_word("rx_bp_word1");
      pop_word("rx_bp_word2");
      @(negedge clk);
      tot_cnt++; if (in_stall !== 1'b1 || exp_rx_q.size() != 0) $display("FAIL rx_bp_end: in_stall=%b left=%0d expected 1 and 0", in_stall, exp_rx_q.size()); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_send();
      int beats;
      do_reset();
      tx_ready = 1'b1;
      push_word(32'h44332211, 1'b1);
      beats = 0;
      for (int k = 0; k < 20 && beats < 2; k++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) beats++;
      end
      @(posedge clk);
      #2;
      tot_cnt++; if (result_bytes !== 32'd2 || tx_valid !== 1'b1) $display("FAIL mid_pre: result=%0d tx_valid=%b expected 2 and 1", result_bytes, tx_valid); else pass_cnt++;
      rst = 1'b0;
      #1;
      tot_cnt++; if (tx_valid !== 1'b0 || result_bytes !== 32'd0 || status !== 32'h4)
         $display("FAIL mid_async: tx_valid=%b result=%h status=%h expected 0 0 00000004", tx_valid, result_bytes, status);
      else pass_cnt++;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      tot_cnt++; if (tx_valid !== 1'b0 || result_bytes !== 32'd0 || status !== 32'h4)
         $display("FAIL mid_after: tx_valid=%b result=%h status=%h expected 0 0 00000004", tx_valid, result_bytes, status);
      else pass_cnt++;
      exp_tx_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_tx_full();
      test_rx_word();
      test_rx_backpressure();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
`default_nettype wire
